// File: rtl/flash_pkg.sv
// Shared types and default timing for the parallel flash responder.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_OUTPUT,
        ST_VALID,
        ST_WRITE,
        ST_PROG
    } flash_state_t;

    localparam logic [15:0] FLASH_ERASED = 16'hFFFF;

    localparam int FLASH_DEPTH = 256;
    localparam int FLASH_TACC  = 6;
    localparam int FLASH_TOE   = 3;
    localparam int FLASH_TPROG = 4;

endpackage

// File: rtl/flex_counter.sv
// Saturating sample counter: clear to 0, restart at 1, otherwise count up to MAX.
module flex_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 6
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             restart,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count register; restart loads 1 because the restarting sample itself counts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (restart) begin
            count <= WIDTH'(1);
        end else if (enable && (count != WIDTH'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/flash_responder.sv
// Parallel flash target model: timed reads, NOR-style programming, preload side port.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  ST_IDLE   | ce high, bus released
//  ST_ACCESS | ce low, oe high (or just dropped): counting access time
//  ST_OUTPUT | ce and oe low, waiting for both access and oe timing
//  ST_VALID  | data holds the addressed word
//  ST_WRITE  | we sampled low, address/wdata latched, waiting for we rise
//  ST_PROG   | program in progress, busy high
module flash_responder
    import flash_pkg::*;
#(
    parameter int DEPTH = FLASH_DEPTH,
    parameter int TACC  = FLASH_TACC,
    parameter int TOE   = FLASH_TOE,
    parameter int TPROG = FLASH_TPROG
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        ce,
    input  logic        oe,
    input  logic        we,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        busy,
    output logic        protocol_err,
    input  logic        pl_en,
    input  logic [15:0] pl_addr,
    input  logic [15:0] pl_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(TACC + 1);
    localparam int OW = $clog2(TOE + 1);
    localparam int PW = $clog2(TPROG + 1);

    flash_state_t  state_q, state_d;
    logic [CW-1:0] ce_cnt;
    logic          ce_clear, ce_restart, ce_inc, ce_ready;
    logic [OW-1:0] oe_cnt_q, oe_cnt_d;
    logic [PW-1:0] prog_cnt_q, prog_cnt_d;
    logic [15:0]   addr_q, prog_addr_q, prog_data_q;
    logic [15:0]   data_d, rd_word;
    logic          valid_d, busy_d, err_d;
    logic          latch_wr, prog_wr;
    logic          addr_chg, rd_in_range, pl_in_range, prog_in_range;
    logic [15:0]   mem [DEPTH];

    assign addr_chg      = (address != addr_q);
    assign rd_in_range   = int'(address) < DEPTH;
    assign pl_in_range   = int'(pl_addr) < DEPTH;
    assign prog_in_range = int'(prog_addr_q) < DEPTH;
    assign rd_word       = rd_in_range ? mem[address[IW-1:0]] : FLASH_ERASED;

    flex_counter #(
        .WIDTH (CW),
        .MAX   (TACC)
    ) u_ce_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (ce_clear),
        .restart (ce_restart),
        .enable  (ce_inc),
        .count   (ce_cnt)
    );

    // Next-state and output decode; bus combination priority: ce, then state, then oe/we.
    always_comb begin
        state_d    = state_q;
        oe_cnt_d   = oe_cnt_q;
        prog_cnt_d = prog_cnt_q;
        data_d     = data;
        valid_d    = data_valid;
        busy_d     = busy;
        err_d      = protocol_err;
        ce_clear   = 1'b0;
        ce_restart = 1'b0;
        ce_inc     = 1'b0;
        ce_ready   = 1'b0;
        latch_wr   = 1'b0;
        prog_wr    = 1'b0;
        if (ce) begin
            state_d    = ST_IDLE;
            ce_clear   = 1'b1;
            oe_cnt_d   = '0;
            prog_cnt_d = '0;
            data_d     = '0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
        end else begin
            // A new address (or first ce-low sample) starts a fresh access.
            ce_restart = (state_q == ST_IDLE) || addr_chg;
            ce_inc     = !ce_restart;
            ce_ready   = !ce_restart && (ce_cnt >= CW'(TACC - 1));
            if (oe) begin
                oe_cnt_d = '0;
            end else if (oe_cnt_q != OW'(TOE)) begin
                oe_cnt_d = oe_cnt_q + 1'b1;
            end
            unique case (state_q)
                ST_PROG: begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    if (!we) begin
                        err_d = 1'b1;
                    end
                    if (prog_cnt_q == '0) begin
                        state_d = ST_ACCESS;
                        busy_d  = 1'b0;
                    end else begin
                        prog_cnt_d = prog_cnt_q - 1'b1;
                    end
                end
                ST_WRITE: begin
                    data_d  = '0;
                    valid_d = 1'b0;
                    if (!we && !oe) begin
                        err_d    = 1'b1;
                        oe_cnt_d = '0;
                        state_d  = ST_ACCESS;
                    end else if (!we) begin
                        latch_wr = 1'b1;
                    end else begin
                        prog_wr    = 1'b1;
                        busy_d     = 1'b1;
                        prog_cnt_d = PW'(TPROG - 1);
                        state_d    = ST_PROG;
                    end
                end
                default: begin
                    if (!we && !oe) begin
                        err_d    = 1'b1;
                        oe_cnt_d = '0;
                        data_d   = '0;
                        valid_d  = 1'b0;
                        state_d  = ST_ACCESS;
                    end else if (!we) begin
                        latch_wr = 1'b1;
                        data_d   = '0;
                        valid_d  = 1'b0;
                        state_d  = ST_WRITE;
                    end else if (oe) begin
                        data_d  = '0;
                        valid_d = 1'b0;
                        state_d = ST_ACCESS;
                    end else if (data_valid && !addr_chg) begin
                        state_d = ST_VALID;
                    end else if (ce_ready && (oe_cnt_q >= OW'(TOE - 1))) begin
                        data_d  = rd_word;
                        valid_d = 1'b1;
                        state_d = ST_VALID;
                    end else begin
                        data_d  = '0;
                        valid_d = 1'b0;
                        state_d = ST_OUTPUT;
                    end
                end
            endcase
        end
    end

    // State, timers, outputs and the program address/data latch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            oe_cnt_q     <= '0;
            prog_cnt_q   <= '0;
            addr_q       <= '0;
            prog_addr_q  <= '0;
            prog_data_q  <= '0;
            data         <= '0;
            data_valid   <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            oe_cnt_q     <= oe_cnt_d;
            prog_cnt_q   <= prog_cnt_d;
            addr_q       <= address;
            data         <= data_d;
            data_valid   <= valid_d;
            busy         <= busy_d;
            protocol_err <= err_d;
            if (latch_wr) begin
                prog_addr_q <= address;
                prog_data_q <= wdata;
            end
        end
    end

    // Word array; preload is written last so it wins over a same-edge program.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= FLASH_ERASED;
            end
        end else begin
            if (prog_wr && prog_in_range) begin
                mem[prog_addr_q[IW-1:0]] <= mem[prog_addr_q[IW-1:0]] & prog_data_q;
            end
            if (pl_en && pl_in_range) begin
                mem[pl_addr[IW-1:0]] <= pl_data;
            end
        end
    end

endmodule
